dot_product_accumulator: RTL
============================

Name: dot_product_accumulator

Overview:
- Downstream consumer of pipelined_multiplier: takes its product/out_valid stream and sums each fixed-length frame of LEN products into one dot-product result.
- Presents each result on a valid/ready output port with a one-entry holding register.
- The multiplier has no backpressure, so this block never stalls its input; it flags and drops results it cannot hold.

Parameters:
- N, 4, operand width of the upstream multiplier; product width is 2*N.
- LEN, 8, products per frame; legal range 2..256.
- ACC_W (localparam, not overridable), 2*N + clog2(LEN), accumulator and result width; 11 at defaults.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  product is valid this cycle; driven by multiplier out_valid.
- product  in  2*N  unsigned product from the multiplier.
- clear  in  1  synchronous frame abort and flag clear.
- sum  out  ACC_W  completed frame sum.
- sum_valid  out  1  sum holds an unconsumed result.
- sum_ready  in  1  downstream accepts sum this cycle.
- drop_err  out  1  sticky: a completed result was dropped.
- elem_cnt  out  clog2(LEN)  products accumulated so far in the current frame.

Behaviour:
- Reset (async, rst=1): acc=0, elem_cnt=0, sum=0, sum_valid=0, drop_err=0, FSM=IDLE.
- FSM states:
  - IDLE: elem_cnt==0, acc meaningless.
  - ACCUM: partial frame in progress.
  - IDLE -> ACCUM on in_valid when LEN>1.
  - ACCUM -> IDLE on the LEN-th accepted product, or on clear.
- Accumulate: on in_valid, acc <= (elem_cnt==0 ? zext(product) : acc + zext(product)); elem_cnt increments.
  - Arithmetic is unsigned and zero-extended to ACC_W. Overflow is impossible by construction.
- Frame completion: the in_valid cycle with elem_cnt==LEN-1 is the completion cycle.
  - Completed value = acc + product.
  - elem_cnt wraps to 0.
  - A product arriving the following cycle starts a new frame with no bubble.
- Latency: sum_valid rises on the clock edge that accepts the LEN-th product, i.e. it is visible 1 cycle after that product was presented.
- Output handshake:
  - A transfer occurs when sum_valid && sum_ready at a rising edge.
  - sum is stable while sum_valid=1 and sum_ready=0.
  - sum_valid falls after a transfer unless a new completion occurs in the same cycle.
- Simultaneous completion and output slot:
  - Completion && (!sum_valid || sum_ready): load new result, sum_valid=1.
  - Completion && sum_valid && !sum_ready: keep old result, discard new one, set drop_err=1. The accumulator still restarts from 0.
- in_valid with sum_valid pending: accumulation always continues; input is never stalled.
- clear:
  - Sets elem_cnt=0, sum_valid=0 and drop_err=0; the FSM goes to IDLE.
  - Has priority over in_valid and sum_ready in the same cycle; that cycle's product is discarded.
- Reset mid-frame: partial sum is lost, and all outputs return to their reset values immediately.
- drop_err clears only on rst or clear.

Optional Feature:
- Macro: DOT_PRODUCT_FRAME_CNT_EN.
- When defined:
  - Adds output port frame_cnt [7:0], counting results transferred on the output handshake.
  - Wraps 255 -> 0.
  - Reset to 0 by rst or clear.
  - Not incremented for dropped results.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package dot_product_pkg:
  - clog2 constant function.
  - Default N and LEN.
  - ACC_W derivation function.
  - FSM state enum/localparams (IDLE, ACCUM).
- Sub-module result_hold_reg: one-entry valid/ready holding register with a load input and a drop indication. Parameter W.
- The accumulator, counter and FSM live in the top module.

Test Plan (N=4, LEN=8, so ACC_W=11):
- Reset mid-frame:
  - Stimulus: feed 3 products, then assert rst.
  - Response: elem_cnt=0, sum_valid=0 immediately; the next full frame sums correctly with no carry-over.
- Basic frame:
  - Stimulus: products 1..8 on consecutive cycles, sum_ready=1.
  - Response: one cycle after product 8, sum=36 and sum_valid=1 for exactly 1 cycle.
- Max values:
  - Stimulus: 8 products of 225 (15*15) back-to-back.
  - Response: sum=1800, no wrap; elem_cnt returns to 0.
- Backpressure and drop:
  - Stimulus: sum_ready=0; frame A = eight 1s; frame B = eight 2s.
  - Response: sum=8 held stable and drop_err=1 after frame B completes.
  - Then sum_ready=1 for 1 cycle: sum_valid falls; drop_err stays 1.
- Simultaneous consume and complete:
  - Stimulus: frame A result pending; assert sum_ready in the same cycle frame B (eight 3s) completes.
  - Response: the next cycle shows sum=24 with sum_valid=1; drop_err=0.
- Clear with in_valid:
  - Stimulus: after 5 products of value 4, assert clear together with in_valid (product=9).
  - Response: elem_cnt=0 and the 9 is discarded; the following frame of eight 1s yields sum=8.
  - With DOT_PRODUCT_FRAME_CNT_EN: frame_cnt increments once per output transfer.

Source files
------------

// File: rtl/dot_product_pkg.sv
// Shared constants, FSM encoding and width helpers for the dot-product accumulator.
// Optional feature macro: DOT_PRODUCT_FRAME_CNT_EN (see dot_product_accumulator.sv).
package dot_product_pkg;

    localparam int unsigned DEFAULT_N   = 4;
    localparam int unsigned DEFAULT_LEN = 8;

    // IDLE: no partial frame held; ACCUM: partial frame in progress
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Ceiling log2 for elaboration-time widths
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

    // Accumulator width: product width plus headroom for LEN terms
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned len);
        return 2 * n + clog2(len);
    endfunction

endpackage

// File: rtl/result_hold_reg.sv
// One-entry valid/ready holding register; a load that finds the slot full
// is discarded and raises a sticky drop flag.
module result_hold_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         drop
);

    // Slot update: clear wins, then load into a free/draining slot, else drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
            drop  <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
            drop  <= 1'b0;
        end else if (load && (!valid || ready)) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (load) begin
            drop  <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dot_product_accumulator.sv
// Sums each frame of LEN products from the upstream multiplier into one result
// and offers it on a valid/ready port; never stalls its input.
// Optional: define DOT_PRODUCT_FRAME_CNT_EN to add an 8-bit count of
// results transferred on the output handshake (frame_cnt).
module dot_product_accumulator
    import dot_product_pkg::*;
#(
    parameter  int unsigned N      = DEFAULT_N,
    parameter  int unsigned LEN    = DEFAULT_LEN,
    localparam int unsigned ACC_W  = acc_width(N, LEN),
    localparam int unsigned CNT_W  = clog2(LEN),
    localparam int unsigned PROD_W = 2 * N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] product,
    input  logic              clear,
    output logic [ACC_W-1:0]  sum,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              drop_err,
`ifdef DOT_PRODUCT_FRAME_CNT_EN
    output logic [7:0]        frame_cnt,
`endif
    output logic [CNT_W-1:0]  elem_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   acc_next;
    logic               frame_done_c;

    // First product of a frame replaces the stale accumulator contents
    assign prod_ext     = ACC_W'(product);
    assign acc_next     = (state == ST_IDLE) ? prod_ext : acc + prod_ext;
    assign frame_done_c = in_valid && !clear && (elem_cnt == LAST_IDX);

    // Frame FSM, element counter and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            acc      <= '0;
            elem_cnt <= '0;
        end else if (clear) begin
            state    <= ST_IDLE;
            elem_cnt <= '0;
        end else if (in_valid) begin
            if (elem_cnt == LAST_IDX) begin
                state    <= ST_IDLE;
                elem_cnt <= '0;
                acc      <= '0;
            end else begin
                state    <= ST_ACCUM;
                elem_cnt <= elem_cnt + CNT_W'(1);
                acc      <= acc_next;
            end
        end
    end

    result_hold_reg #(
        .W (ACC_W)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load      (frame_done_c),
        .load_data (acc_next),
        .ready     (sum_ready),
        .data      (sum),
        .valid     (sum_valid),
        .drop      (drop_err)
    );

`ifdef DOT_PRODUCT_FRAME_CNT_EN
    // Count results actually handed downstream; wraps naturally at 8 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (clear) begin
            frame_cnt <= 8'd0;
        end else if (sum_valid && sum_ready) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule
